// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU, one request in flight, valid/ready on both sides.
// Ports: clk, rst_n, in_valid/in_ready/op/a/b in, out_valid/out_ready/result/err out.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               err
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;

  localparam logic [WIDTH-1:0] W_LIM = WIDTH[WIDTH-1:0];
  // first of the WIDTH steps runs on the accept edge
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           op_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   res_d;
  logic                 err_d;
  logic                 accept;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  // single-cycle results
  logic [WIDTH:0]       add_w, sub_w;
  logic [2*WIDTH-1:0]   alu_res;
  logic                 alu_err;
  logic                 alu_multi;

  assign add_w = {1'b0, a} + {1'b0, b};
  // bit WIDTH is the borrow
  assign sub_w = {1'b0, a} - {1'b0, b};

  always_comb begin
    alu_res   = '0;
    alu_err   = 1'b0;
    alu_multi = 1'b0;
    case (op)
      OP_ADD: alu_res = {{(WIDTH-1){1'b0}}, add_w};
      OP_SUB: alu_res = {{(WIDTH-1){1'b0}}, sub_w};
      OP_AND: alu_res[WIDTH-1:0] = a & b;
      OP_OR:  alu_res[WIDTH-1:0] = a | b;
      OP_XOR: alu_res[WIDTH-1:0] = a ^ b;
      OP_NOT: alu_res[WIDTH-1:0] = ~a;
      OP_SLL: alu_res[WIDTH-1:0] = (b >= W_LIM) ? '0 : (a << b);
      OP_SRL: alu_res[WIDTH-1:0] = (b >= W_LIM) ? '0 : (a >> b);
      OP_MUL: alu_multi = 1'b1;
      OP_DIV: begin
        if (b == '0) begin
          alu_res = {a, {WIDTH{1'b1}}};
          alu_err = 1'b1;
        end else begin
          alu_multi = 1'b1;
        end
      end
      default: alu_err = 1'b1;
    endcase
  end

  // one iteration datapath, fed from the raw inputs on the
  // accept edge and from the captured operands while BUSY
  logic                 st_mul;
  logic [WIDTH-1:0]     st_a, st_b;
  logic [2*WIDTH-1:0]   st_p, st_next;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_sh, div_diff;

  always_comb begin
    if (state_q == IDLE) begin
      st_mul = (op == OP_MUL);
      st_a   = a;
      st_b   = b;
      st_p   = st_mul ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
    end else begin
      st_mul = (op_q == OP_MUL);
      st_a   = a_q;
      st_b   = b_q;
      st_p   = p_q;
    end
  end

  // shift-add: high half accumulates, multiplier drains from low half
  assign mul_sum = {1'b0, st_p[2*WIDTH-1:WIDTH]}
                 + (st_p[0] ? {1'b0, st_a} : '0);
  // restoring: high half is remainder, low half shifts in quotient
  assign div_sh   = {st_p[2*WIDTH-1:WIDTH], st_p[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, st_b};

  always_comb begin
    if (st_mul)
      st_next = {mul_sum, st_p[WIDTH-1:1]};
    else if (!div_diff[WIDTH])
      st_next = {div_diff[WIDTH-1:0], st_p[WIDTH-2:0], 1'b1};
    else
      st_next = {div_sh[WIDTH-1:0], st_p[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    res_d   = result;
    err_d   = err;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (alu_multi) begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
            p_d     = st_next;
          end else begin
            state_d = DONE;
            res_d   = alu_res;
            err_d   = alu_err;
          end
        end
      end
      BUSY: begin
        p_d = st_next;
        if (cnt_q == '0) begin
          state_d = DONE;
          res_d   = st_next;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      result  <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      result  <= res_d;
      err     <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= op;
      a_q  <= a;
      b_q  <= b;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed test of seq_alu at WIDTH=16.
// Each task drives one scenario and checks inline.
module tb_seq_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        err;

  int checks;
  int errors;

  seq_alu #(.WIDTH(16), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accept one request, scramble inputs, measure latency, handshake.
  task automatic run_op(input logic [3:0] o, input logic [15:0] x,
                        input logic [15:0] y, output logic [31:0] r,
                        output logic e, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'hF; a = 16'hA5A5; b = 16'h0000;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    r = result; e = err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    #3;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        result !== 32'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b res=%h err=%b want 1 0 0 0",
               in_ready, out_valid, result, err);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    logic [31:0] r; logic e; int lat;
    run_op(4'd0, 16'd3080, 16'd756, r, e, lat);
    checks++;
    if (r !== 32'd3836 || e !== 1'b0 || lat !== 1) begin
      errors++;
      $display("FAIL add1: res=%0d err=%b lat=%0d want 3836 0 1", r, e, lat);
    end
    run_op(4'd0, 16'hFFFF, 16'd1, r, e, lat);
    checks++;
    if (r !== 32'h10000 || e !== 1'b0 || lat !== 1) begin
      errors++;
      $display("FAIL add_carry: res=%h err=%b lat=%0d want 10000 0 1",
               r, e, lat);
    end
  endtask

  task automatic test_mul;
    logic [31:0] r; logic e; int lat;
    run_op(4'd8, 16'd3080, 16'd756, r, e, lat);
    checks++;
    if (r !== 32'd2328480 || e !== 1'b0 || lat !== 16) begin
      errors++;
      $display("FAIL mul1: res=%0d err=%b lat=%0d want 2328480 0 16",
               r, e, lat);
    end
    run_op(4'd8, 16'hFFFF, 16'hFFFF, r, e, lat);
    checks++;
    if (r !== 32'hFFFE0001 || lat !== 16) begin
      errors++;
      $display("FAIL mul_max: res=%h lat=%0d want fffe0001 16", r, lat);
    end
  endtask

  task automatic test_div;
    logic [31:0] r; logic e; int lat;
    run_op(4'd9, 16'd3080, 16'd756, r, e, lat);
    checks++;
    if (r !== 32'h00380004 || e !== 1'b0 || lat !== 16) begin
      errors++;
      $display("FAIL div1: res=%h err=%b lat=%0d want 00380004 0 16",
               r, e, lat);
    end
    run_op(4'd9, 16'd100, 16'd7, r, e, lat);
    checks++;
    if (r !== 32'h0002000E || e !== 1'b0) begin
      errors++;
      $display("FAIL div2: res=%h err=%b want 0002000e 0", r, e);
    end
    run_op(4'd9, 16'd5, 16'd0, r, e, lat);
    checks++;
    if (r !== 32'h0005FFFF || e !== 1'b1 || lat !== 1) begin
      errors++;
      $display("FAIL div0: res=%h err=%b lat=%0d want 0005ffff 1 1",
               r, e, lat);
    end
  endtask

  task automatic test_logic;
    logic [31:0] r; logic e; int lat;
    run_op(4'd2, 16'hF0F0, 16'h0FF0, r, e, lat);
    checks++;
    if (r !== 32'h000000F0 || e !== 1'b0) begin
      errors++;
      $display("FAIL and: res=%h err=%b want 000000f0 0", r, e);
    end
    run_op(4'd3, 16'hF000, 16'h000F, r, e, lat);
    checks++;
    if (r !== 32'h0000F00F) begin
      errors++;
      $display("FAIL or: res=%h want 0000f00f", r);
    end
    run_op(4'd4, 16'hFFFF, 16'h0F0F, r, e, lat);
    checks++;
    if (r !== 32'h0000F0F0) begin
      errors++;
      $display("FAIL xor: res=%h want 0000f0f0", r);
    end
    run_op(4'd5, 16'h00FF, 16'h1234, r, e, lat);
    checks++;
    if (r !== 32'h0000FF00 || e !== 1'b0) begin
      errors++;
      $display("FAIL not: res=%h err=%b want 0000ff00 0", r, e);
    end
  endtask

  task automatic test_shift;
    logic [31:0] r; logic e; int lat;
    run_op(4'd6, 16'd9568, 16'd1, r, e, lat);
    checks++;
    if (r !== 32'd19136 || e !== 1'b0 || lat !== 1) begin
      errors++;
      $display("FAIL sll1: res=%0d err=%b lat=%0d want 19136 0 1",
               r, e, lat);
    end
    run_op(4'd7, 16'd9568, 16'd1, r, e, lat);
    checks++;
    if (r !== 32'd4784 || e !== 1'b0) begin
      errors++;
      $display("FAIL srl1: res=%0d err=%b want 4784 0", r, e);
    end
    run_op(4'd6, 16'd9568, 16'd16, r, e, lat);
    checks++;
    if (r !== 32'd0) begin
      errors++;
      $display("FAIL sll16: res=%0d want 0", r);
    end
    run_op(4'd7, 16'hFFFF, 16'd16, r, e, lat);
    checks++;
    if (r !== 32'd0) begin
      errors++;
      $display("FAIL srl16: res=%0d want 0", r);
    end
    run_op(4'd12, 16'd9568, 16'd1, r, e, lat);
    checks++;
    if (r !== 32'd0 || e !== 1'b1 || lat !== 1) begin
      errors++;
      $display("FAIL illegal: res=%h err=%b lat=%0d want 0 1 1",
               r, e, lat);
    end
  endtask

  task automatic test_backpressure;
    int bad;
    bad = 0;
    in_valid = 1'b1; op = 4'd1; a = 16'd3; b = 16'd5;
    @(posedge clk); #1;
    // keep a second request pending; it must not be taken
    op = 4'd0; a = 16'd1; b = 16'd1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || result !== 32'h0001FFFE ||
          err !== 1'b0 || in_ready !== 1'b0)
        bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sub_hold: bad cycles=%0d res=%h want 0 and 0001fffe",
               bad, result);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sub_release: rdy=%b vld=%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    logic [31:0] r; logic e; int lat;
    in_valid = 1'b1; op = 4'd8; a = 16'd3080; b = 16'd756;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid: vld=%b rdy=%b res=%h want 0 1 0",
               out_valid, in_ready, result);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      if (out_valid !== 1'b0 || result !== 32'h0) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_stale: stale cycles=%0d want 0", seen);
    end
    run_op(4'd0, 16'd10, 16'd20, r, e, lat);
    checks++;
    if (r !== 32'd30 || lat !== 1) begin
      errors++;
      $display("FAIL rst_after: res=%0d lat=%0d want 30 1", r, lat);
    end
  endtask

  task automatic test_back_to_back;
    int gap;
    logic [31:0] r; logic e; int lat;
    run_op(4'd0, 16'd1, 16'd2, r, e, lat);
    gap = 0;
    if (!in_ready) gap = 1;
    run_op(4'd2, 16'hFF00, 16'h0FF0, r, e, lat);
    checks++;
    if (gap != 0 || r !== 32'h00000F00 || lat !== 1) begin
      errors++;
      $display("FAIL b2b: gap=%0d res=%h lat=%0d want 0 00000f00 1",
               gap, r, lat);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_add;
    test_mul;
    test_div;
    test_logic;
    test_shift;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
